// File: rtl/mem_write_monitor_if.sv
// Store-port and trace-stream bundle between the MIPS data-memory write port,
// the store monitor and the trace consumer.
interface mem_write_monitor_if;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;

    modport master (
        output memwrite,
        output dataadr,
        output writedata,
        output out_ready,
        input  out_valid,
        input  out_addr,
        input  out_data
    );

    modport slave (
        input  memwrite,
        input  dataadr,
        input  writedata,
        input  out_ready,
        output out_valid,
        output out_addr,
        output out_data
    );
endinterface

// File: rtl/mem_write_monitor.sv
// Captures every store of the MIPS core into a fall-through trace FIFO and
// judges the test program's pass/fail store rule.
module mem_write_monitor #(
    parameter int unsigned DEPTH        = 8,
    parameter logic [31:0] PASS_ADDR    = 32'd84,
    parameter logic [31:0] PASS_DATA    = 32'd7,
    parameter logic [31:0] ALLOWED_ADDR = 32'd80
) (
    input  logic                         clk,
    input  logic                         reset,
    mem_write_monitor_if.slave           bus,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         done,
    output logic                         pass
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_FAIL = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    logic [1:0]    state;
    logic [1:0]    state_next;
    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          empty;
    logic          full;
    logic          sample;
    logic          pop;
    logic          push;
    logic          drop;

    // Handshake decode; pop only qualifies on the registered occupancy.
    always_comb begin
        empty  = (count_q == '0);
        full   = (count_q == CW'(DEPTH));
        sample = bus.memwrite && (state == ST_RUN);
        pop    = !empty && bus.out_ready;
        push   = sample && (!full || pop);
        drop   = sample && full && !pop;
    end

    // Checker next state: the terminating store is still judged when dropped.
    always_comb begin
        state_next = state;
        if (state == ST_RUN && bus.memwrite) begin
            if (bus.dataadr == PASS_ADDR && bus.writedata == PASS_DATA) begin
                state_next = ST_PASS;
            end else if (bus.dataadr != ALLOWED_ADDR) begin
                state_next = ST_FAIL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_t'{addr: bus.dataadr, data: bus.writedata};
        end
    end

    assign head          = mem[rd_ptr];
    assign bus.out_valid = !empty;
    assign bus.out_addr  = empty ? 32'd0 : head.addr;
    assign bus.out_data  = empty ? 32'd0 : head.data;
    assign count         = count_q;
    assign done          = (state != ST_RUN);
    assign pass          = (state == ST_PASS);

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed bench for mem_write_monitor: trace ordering, pass/fail judgement,
// full/overflow corners and asynchronous reset.
module tb_mem_write_monitor;

    logic       clk;
    logic       reset;
    logic [3:0] count;
    logic       overflow;
    logic       done;
    logic       pass;
    int         n_cmp;
    int         n_err;

    mem_write_monitor_if bus ();

    mem_write_monitor #(
        .DEPTH        (8),
        .PASS_ADDR    (32'd84),
        .PASS_DATA    (32'd7),
        .ALLOWED_ADDR (32'd80)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .count    (count),
        .overflow (overflow),
        .done     (done),
        .pass     (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.memwrite  = 1'b1;
        bus.dataadr   = a;
        bus.writedata = d;
        tick();
        bus.memwrite  = 1'b0;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        bus.memwrite  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b0;
        bus.memwrite  = 1'b0;
        bus.dataadr   = 32'd0;
        bus.writedata = 32'd0;
        bus.out_ready = 1'b0;

        // Reset and idle
        do_reset();
        repeat (2) tick();
        chk("idle_count", 32'(count), 32'd0);
        chk("idle_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_pass", 32'(pass), 32'd0);
        chk("idle_ovf", 32'(overflow), 32'd0);
        chk("idle_addr", bus.out_addr, 32'd0);
        chk("idle_data", bus.out_data, 32'd0);

        // Passing program with consumer always ready
        bus.out_ready = 1'b1;
        store(32'd80, 32'd7);
        chk("p1_count", 32'(count), 32'd1);
        chk("p1_addr", bus.out_addr, 32'd80);
        chk("p1_data", bus.out_data, 32'd7);
        chk("p1_done", 32'(done), 32'd0);
        store(32'd80, 32'd3);
        chk("p2_count", 32'(count), 32'd1);
        chk("p2_data", bus.out_data, 32'd3);
        store(32'd84, 32'd7);
        chk("p3_addr", bus.out_addr, 32'd84);
        chk("p3_data", bus.out_data, 32'd7);
        chk("p3_done", 32'(done), 32'd1);
        chk("p3_pass", 32'(pass), 32'd1);
        store(32'd80, 32'd1);
        chk("p4_count", 32'(count), 32'd0);
        chk("p4_valid", 32'(bus.out_valid), 32'd0);
        chk("p4_done", 32'(done), 32'd1);
        chk("p4_pass", 32'(pass), 32'd1);

        // Wrong data at the pass address
        do_reset();
        store(32'd84, 32'd5);
        chk("f1_done", 32'(done), 32'd1);
        chk("f1_pass", 32'(pass), 32'd0);
        chk("f1_count", 32'(count), 32'd1);
        chk("f1_addr", bus.out_addr, 32'd84);
        chk("f1_data", bus.out_data, 32'd5);
        store(32'd80, 32'd9);
        chk("f1_ignored", 32'(count), 32'd1);

        // Disallowed address
        do_reset();
        store(32'd60, 32'd1);
        chk("f2_done", 32'(done), 32'd1);
        chk("f2_pass", 32'(pass), 32'd0);
        chk("f2_addr", bus.out_addr, 32'd60);
        chk("f2_data", bus.out_data, 32'd1);

        // Overflow: nine stores into an eight-deep FIFO
        do_reset();
        for (int i = 1; i <= 8; i++) store(32'd80, 32'(i));
        chk("o_count8", 32'(count), 32'd8);
        chk("o_ovf0", 32'(overflow), 32'd0);
        store(32'd80, 32'd9);
        chk("o_count9", 32'(count), 32'd8);
        chk("o_ovf1", 32'(overflow), 32'd1);
        chk("o_done", 32'(done), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("o_drain%0d", i), bus.out_data, 32'(i));
            tick();
        end
        chk("o_empty", 32'(count), 32'd0);
        chk("o_ovf_sticky", 32'(overflow), 32'd1);

        // Full with simultaneous push and pop
        do_reset();
        for (int i = 11; i <= 18; i++) store(32'd80, 32'(i));
        chk("s_count8", 32'(count), 32'd8);
        bus.out_ready = 1'b1;
        store(32'd80, 32'd19);
        chk("s_count", 32'(count), 32'd8);
        chk("s_ovf", 32'(overflow), 32'd0);
        for (int i = 12; i <= 19; i++) begin
            chk($sformatf("s_drain%0d", i), bus.out_data, 32'(i));
            tick();
        end
        chk("s_empty", 32'(count), 32'd0);

        // Asynchronous reset mid-drain
        do_reset();
        for (int i = 21; i <= 23; i++) store(32'd80, 32'(i));
        chk("r_count3", 32'(count), 32'd3);
        bus.out_ready = 1'b1;
        reset = 1'b0;
        #1;
        chk("r_count", 32'(count), 32'd0);
        chk("r_valid", 32'(bus.out_valid), 32'd0);
        chk("r_addr", bus.out_addr, 32'd0);
        tick();
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        store(32'd80, 32'd42);
        chk("r_after_count", 32'(count), 32'd1);
        chk("r_after_data", bus.out_data, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
